// File: rtl/alu_pkg.sv
// Shared opcode encoding, result width, per-entry bundle type and result selection.
// ALU_FLAGS_EN adds zero/negative flags to every stored bundle.
package alu_pkg;

  localparam int RES_W = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             illegal;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             neg;
`endif
  } bundle_t;

  // Illegal opcodes yield a zero result tagged illegal rather than a stale value.
  function automatic bundle_t select_result(
    input logic [2:0]       op,
    input logic [RES_W-1:0] and_res,
    input logic [RES_W-1:0] or_res,
    input logic [RES_W-1:0] xor_res,
    input logic [RES_W-1:0] nor_res,
    input logic [RES_W-1:0] add_res
  );
    bundle_t b;
    b = '0;
    case (op)
      OP_AND:  b.result = and_res;
      OP_OR:   b.result = or_res;
      OP_XOR:  b.result = xor_res;
      OP_NOR:  b.result = nor_res;
      OP_ADD:  b.result = add_res;
      default: b.illegal = 1'b1;
    endcase
`ifdef ALU_FLAGS_EN
    b.zero = (b.result == '0);
    b.neg  = b.result[RES_W-1];
`endif
    return b;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake and result bus of alu_result_stage.
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_result_stage_if #(
  parameter int ERR_CNT_W = 8
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [RES_W-1:0] and_res;
  logic [RES_W-1:0] or_res;
  logic [RES_W-1:0] xor_res;
  logic [RES_W-1:0] nor_res;
  logic [RES_W-1:0] add_res;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_illegal;
`ifdef ALU_FLAGS_EN
  logic             out_zero;
  logic             out_neg;
`endif
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, op, and_res, or_res, xor_res, nor_res, add_res, out_ready,
    input  in_ready, out_valid, out_result, out_illegal,
`ifdef ALU_FLAGS_EN
    input  out_zero, out_neg,
`endif
    input  err_count
  );

  modport slave (
    input  in_valid, op, and_res, or_res, xor_res, nor_res, add_res, out_ready,
    output in_ready, out_valid, out_result, out_illegal,
`ifdef ALU_FLAGS_EN
    output out_zero, out_neg,
`endif
    output err_count
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer: main register drives the outputs, skid catches the bundle
// accepted while downstream stalls. in_ready is registered to cut the out_ready path.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q != ST_EMPTY) && out_ready;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: data registers are reset too, because the cleared payload is visible on the outputs.
  // NOTE: non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects the result by opcode, buffers it in a skid buffer and
// counts accepted illegal opcodes (saturating). ALU_FLAGS_EN adds zero/neg flags.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  alu_result_stage_if.slave bus
);

  bundle_t              in_bundle, out_bundle;
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign in_bundle = select_result(bus.op, bus.and_res, bus.or_res, bus.xor_res,
                                   bus.nor_res, bus.add_res);
  assign accept    = bus.in_valid && bus.in_ready;

  alu_skid_buf #(
    .W($bits(bundle_t))
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (in_bundle),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_bundle)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && in_bundle.illegal && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_result  = out_bundle.result;
  assign bus.out_illegal = out_bundle.illegal;
`ifdef ALU_FLAGS_EN
  assign bus.out_zero    = out_bundle.zero;
  assign bus.out_neg     = out_bundle.neg;
`endif
  assign bus.err_count   = err_cnt_q;

endmodule
